// File: rtl/multisim_pull_downsizer.sv
// Elastic FIFO stage that splits IN_WIDTH words from the multisim pull client into OUT_WIDTH beats.
// Define MULTISIM_DOWNSIZER_MSB_FIRST_EN to emit the most significant slice of each word first.
module multisim_pull_downsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [IN_WIDTH-1:0]          in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    generate
        if ((OUT_WIDTH < 1) || (IN_WIDTH % OUT_WIDTH != 0) || (RATIO < 1)) begin : g_bad_ratio
            $fatal(1, "IN_WIDTH must be a positive integer multiple of OUT_WIDTH");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef logic [RATIO-1:0][OUT_WIDTH-1:0] word_t;

    logic [IN_WIDTH-1:0] mem_q [DEPTH];
    logic [IN_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic                push;
    logic                pop_beat;
    logic                last_beat;
    logic                pop_word;
    word_t               head;
    logic [IDX_W-1:0]    beat_sel;

    always_comb begin
        in_rdy    = (count_q < LVL_W'(DEPTH));
        out_vld   = (count_q != '0);
        push      = in_vld && in_rdy;
        pop_beat  = out_vld && out_rdy;
        last_beat = (idx_q == IDX_W'(RATIO - 1));
        pop_word  = pop_beat && last_beat;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop_beat) begin
            if (last_beat) begin
                idx_d    = '0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Push and final-beat pop together leave the occupancy unchanged.
        case ({push, pop_word})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        head = mem_q[rd_ptr_q];
`ifdef MULTISIM_DOWNSIZER_MSB_FIRST_EN
        beat_sel = IDX_W'(RATIO - 1) - idx_q;
`else
        beat_sel = idx_q;
`endif
        out_data   = out_vld ? head[beat_sel] : '0;
        fifo_level = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

    // Storage needs no reset: nothing is visible until count marks it valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_multisim_pull_downsizer.sv
// Bench for multisim_pull_downsizer: queue-based reference model plus directed literal checks.
// Also exercises a RATIO=1 instance as a plain FIFO.
module tb_multisim_pull_downsizer;

    localparam int DEPTH = 4;
    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_vld = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_rdy = 1'b0;
    logic        in_rdy;
    logic        out_vld;
    logic [15:0] out_data;
    logic [2:0]  fifo_level;

    logic        in_vld1 = 1'b0;
    logic [63:0] in_data1 = '0;
    logic        out_rdy1 = 1'b0;
    logic        in_rdy1;
    logic        out_vld1;
    logic [63:0] out_data1;
    logic [2:0]  fifo_level1;

    multisim_pull_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .fifo_level(fifo_level)
    );

    multisim_pull_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(64), .DEPTH(DEPTH)) dut_r1 (
        .clk(clk), .rst(rst), .in_vld(in_vld1), .in_rdy(in_rdy1), .in_data(in_data1),
        .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1), .fifo_level(fifo_level1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: list of stored words and the index of the next beat of the head word.
    logic [63:0] mq[$];
    int          midx = 0;
    bit          live = 0;

    function automatic logic [15:0] beat_of(input logic [63:0] w, input int k);
        int s;
`ifdef MULTISIM_DOWNSIZER_MSB_FIRST_EN
        s = RATIO - 1 - k;
`else
        s = k;
`endif
        return w[s*16 +: 16];
    endfunction

    bit          m_acc;
    bit          m_xfer;
    logic [63:0] m_tmp;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            midx = 0;
            live = 1;
        end else begin
            m_acc  = in_vld && (mq.size() < DEPTH);
            m_xfer = (mq.size() != 0) && out_rdy;
            if (m_xfer) begin
                if (midx == RATIO - 1) begin
                    m_tmp = mq.pop_front();
                    midx  = 0;
                end else begin
                    midx++;
                end
            end
            if (m_acc) mq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_in_rdy", 64'(in_rdy), 64'(mq.size() < DEPTH));
            chk("m_out_vld", 64'(out_vld), 64'(mq.size() != 0));
            chk("m_out_data", 64'(out_data), (mq.size() != 0) ? 64'(beat_of(mq[0], midx)) : 64'd0);
            chk("m_fifo_level", 64'(fifo_level), 64'(mq.size()));
        end
    end

    task automatic step(input logic v, input logic [63:0] d, input int rmode);
        in_vld  = v;
        in_data = d;
        out_rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode != 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Source holds the word until the handshake completes.
    task automatic push_word(input logic [63:0] d, input int rmode);
        bit ok;
        bit a;
        ok = 0;
        for (int n = 0; n < 64 && !ok; n++) begin
            a = in_rdy;
            step(1'b1, d, rmode);
            if (a) ok = 1;
        end
        in_vld = 1'b0;
        if (!ok) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int rmode);
        int n;
        n = 0;
        while (mq.size() != 0 && n < 400) begin
            step(1'b0, 64'd0, rmode);
            n++;
        end
        if (mq.size() != 0) chk("drain_timeout", 64'(mq.size()), 64'd0);
    endtask

    logic [63:0] w0;
    logic [15:0] eb [4];
    int          wait_n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef MULTISIM_DOWNSIZER_MSB_FIRST_EN
        eb[0] = 16'h4444; eb[1] = 16'h3333; eb[2] = 16'h2222; eb[3] = 16'h1111;
`else
        eb[0] = 16'h1111; eb[1] = 16'h2222; eb[2] = 16'h3333; eb[3] = 16'h4444;
`endif
        w0 = 64'h4444_3333_2222_1111;

        // Reset state
        rst = 1'b1;
        step(1'b0, 64'd0, 0);
        step(1'b0, 64'd0, 0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("r1_rst_out_vld", 64'(out_vld1), 64'd0);
        rst = 1'b0;

        // Single word, beat order and level
        step(1'b1, w0, 1);
        for (int k = 0; k < 4; k++) begin
            chk("single_vld", 64'(out_vld), 64'd1);
            chk("single_beat", 64'(out_data), 64'(eb[k]));
            chk("single_level", 64'(fifo_level), 64'd1);
            step(1'b0, 64'd0, 1);
        end
        chk("single_done_vld", 64'(out_vld), 64'd0);
        chk("single_done_level", 64'(fifo_level), 64'd0);

        // Fill to full with output stalled, then release
        for (int i = 0; i < 4; i++)
            push_word(64'h0A03_0A02_0A01_0A00 + 64'(i) * 64'h0010_0010_0010_0010, 0);
        step(1'b0, 64'd0, 0);
        chk("full_in_rdy", 64'(in_rdy), 64'd0);
        chk("full_level", 64'(fifo_level), 64'd4);
        wait_n = 0;
        while (!in_rdy && wait_n < 20) begin
            step(1'b1, 64'h0A43_0A42_0A41_0A40, 1);
            wait_n++;
        end
        chk("full_release_cycles", 64'(wait_n), 64'd4);
        step(1'b1, 64'h0A43_0A42_0A41_0A40, 1);
        in_vld = 1'b0;
        drain(1);

        // Random backpressure across several pointer wraps
        for (int i = 0; i < 14; i++)
            push_word(64'h1000_2000_3000_4000 + 64'(i), 2);
        drain(2);

        // Push coincident with final-beat pop at count 2
        push_word(64'h5555_6666_7777_8888, 0);
        push_word(64'h9999_AAAA_BBBB_CCCC, 0);
        chk("sim_pre_level", 64'(fifo_level), 64'd2);
        for (int k = 0; k < 3; k++) step(1'b0, 64'd0, 1);
        step(1'b1, 64'hDDDD_EEEE_FFFF_0123, 1);
        in_vld = 1'b0;
        chk("sim_level", 64'(fifo_level), 64'd2);
        drain(1);

        // Reset mid-word with three words stored
        for (int i = 0; i < 3; i++)
            push_word(64'hB003_B002_B001_B000 + 64'(i) * 64'h0100_0100_0100_0100, 0);
        step(1'b0, 64'd0, 1);
        rst = 1'b1;
        step(1'b0, 64'd0, 0);
        chk("mid_rst_out_vld", 64'(out_vld), 64'd0);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        rst = 1'b0;
        step(1'b1, w0, 0);
        in_vld = 1'b0;
        chk("post_rst_beat0", 64'(out_data), 64'(eb[0]));
        drain(1);

        // RATIO=1 instance: one-cycle latency, back-to-back pass-through
        out_rdy1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_vld1  = 1'b1;
            in_data1 = 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0000_1111_0000_0001;
            step(1'b0, 64'd0, 0);
            chk("r1_out_vld", 64'(out_vld1), 64'd1);
            chk("r1_out_data", out_data1, 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0000_1111_0000_0001);
            chk("r1_level", 64'(fifo_level1), 64'd1);
            chk("r1_in_rdy", 64'(in_rdy1), 64'd1);
        end
        in_vld1 = 1'b0;
        step(1'b0, 64'd0, 0);
        chk("r1_idle_vld", 64'(out_vld1), 64'd0);
        chk("r1_idle_level", 64'(fifo_level1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
